ex_mem_stage: RTL and testbench

- EX/MEM pipeline register of the pipelined RV32I core; sits directly downstream of the ALU.
- Captures ALU result/flags plus EX control bundle and resolves conditional branches/jumps from the ALU flags.
- Produces the registered PC redirect (pc_src, target) consumed by fetch and the hazard unit.
- Keeps saturating branch statistics counters.

---
 rtl/ex_mem_stage_if.sv | 41 ++++
 rtl/ex_mem_stage.sv | 145 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bundle: EX-side *_i signals in, registered MEM-side *_o signals out.
interface ex_mem_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             valid_i;
  logic [XLEN-1:0]  alu_r_i;
  logic             cf_i, zf_i, vf_i, sf_i;
  logic [2:0]       funct3_i;
  logic             branch_i, jump_i;
  logic             mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
  logic [4:0]       rd_i;
  logic [XLEN-1:0]  rs2_data_i, target_i, pc_plus4_i;

  logic             valid_o;
  logic [XLEN-1:0]  alu_r_o, rs2_data_o, pc_plus4_o;
  logic [4:0]       rd_o;
  logic             mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o;
  logic [2:0]       funct3_o;
  logic             pc_src_o;
  logic [XLEN-1:0]  target_o;
  logic [CNT_W-1:0] br_count_o, taken_count_o;

  modport master (
    output valid_i, alu_r_i, cf_i, zf_i, vf_i, sf_i, funct3_i, branch_i, jump_i,
           mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i, rd_i,
           rs2_data_i, target_i, pc_plus4_i,
    input  valid_o, alu_r_o, rs2_data_o, pc_plus4_o, rd_o, mem_read_o,
           mem_write_o, reg_write_o, mem_to_reg_o, funct3_o, pc_src_o,
           target_o, br_count_o, taken_count_o
  );

  modport slave (
    input  valid_i, alu_r_i, cf_i, zf_i, vf_i, sf_i, funct3_i, branch_i, jump_i,
           mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i, rd_i,
           rs2_data_i, target_i, pc_plus4_i,
    output valid_o, alu_r_o, rs2_data_o, pc_plus4_o, rd_o, mem_read_o,
           mem_write_o, reg_write_o, mem_to_reg_o, funct3_o, pc_src_o,
           target_o, br_count_o, taken_count_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and controls, resolves branches
// into a registered one-cycle PC redirect, and keeps saturating branch statistics.
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  ex_mem_stage_if.slave bus
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  alu_r_q, alu_r_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic [4:0]       rd_q, rd_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             pc_src_q, pc_src_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  logic cond;
  logic take;
  logic is_br;

  always_comb begin
    cond = 1'b0;
    unique case (bus.funct3_i)
      3'b000:  cond = bus.zf_i;
      3'b001:  cond = ~bus.zf_i;
      3'b100:  cond = bus.sf_i ^ bus.vf_i;
      3'b101:  cond = ~(bus.sf_i ^ bus.vf_i);
      3'b110:  cond = ~bus.cf_i;
      3'b111:  cond = bus.cf_i;
      default: cond = 1'b0;
    endcase
  end

  assign take  = bus.valid_i & (bus.jump_i | (bus.branch_i & cond));
  assign is_br = bus.valid_i & bus.branch_i & ~bus.jump_i;

  always_comb begin
    valid_d       = valid_q;
    alu_r_d       = alu_r_q;
    rs2_data_d    = rs2_data_q;
    pc_plus4_d    = pc_plus4_q;
    rd_d          = rd_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    funct3_d      = funct3_q;
    pc_src_d      = pc_src_q;
    target_d      = target_q;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;

    // A redirect already issued marks the current EX instruction as wrong-path,
    // so it is squashed exactly like an external flush (stall keeps it pending).
    if (flush || (pc_src_q && !stall)) begin
      valid_d      = 1'b0;
      rd_d         = '0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      pc_src_d     = 1'b0;
      target_d     = '0;
    end else if (!stall) begin
      valid_d      = bus.valid_i;
      alu_r_d      = bus.alu_r_i;
      rs2_data_d   = bus.rs2_data_i;
      pc_plus4_d   = bus.pc_plus4_i;
      funct3_d     = bus.funct3_i;
      rd_d         = bus.rd_i;
      mem_read_d   = bus.valid_i & bus.mem_read_i;
      mem_write_d  = bus.valid_i & bus.mem_write_i;
      reg_write_d  = bus.valid_i & bus.reg_write_i;
      mem_to_reg_d = bus.valid_i & bus.mem_to_reg_i;
      pc_src_d     = take;
      target_d     = take ? bus.target_i : '0;
      if (is_br && br_count_q != '1)
        br_count_d = br_count_q + 1'b1;
      if (is_br && cond && taken_count_q != '1)
        taken_count_d = taken_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      alu_r_q       <= '0;
      rs2_data_q    <= '0;
      pc_plus4_q    <= '0;
      rd_q          <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      funct3_q      <= '0;
      pc_src_q      <= 1'b0;
      target_q      <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      alu_r_q       <= alu_r_d;
      rs2_data_q    <= rs2_data_d;
      pc_plus4_q    <= pc_plus4_d;
      rd_q          <= rd_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      funct3_q      <= funct3_d;
      pc_src_q      <= pc_src_d;
      target_q      <= target_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.alu_r_o       = alu_r_q;
  assign bus.rs2_data_o    = rs2_data_q;
  assign bus.pc_plus4_o    = pc_plus4_q;
  assign bus.rd_o          = rd_q;
  assign bus.mem_read_o    = mem_read_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.reg_write_o   = reg_write_q;
  assign bus.mem_to_reg_o  = mem_to_reg_q;
  assign bus.funct3_o      = funct3_q;
  assign bus.pc_src_o      = pc_src_q;
  assign bus.target_o      = target_q;
  assign bus.br_count_o    = br_count_q;
  assign bus.taken_count_o = taken_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; a second instance with 4-bit counters covers saturation.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_stage_if #(.XLEN(32), .CNT_W(16)) bm ();
  ex_mem_stage_if #(.XLEN(32), .CNT_W(4))  bs ();

  ex_mem_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bm.slave)
  );
  ex_mem_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .bus(bs.slave)
  );

  always #5 clk = ~clk;

  // Reference SUB flags: {cf, zf, vf, sf}, cf=1 means no borrow (a >= b unsigned).
  function automatic logic [3:0] sub_flags(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    r = s[31:0];
    return {s[32], (r == 32'd0), (a[31] != b[31]) && (r[31] != a[31]), r[31]};
  endfunction

  task automatic clear_inputs();
    {bm.valid_i, bm.cf_i, bm.zf_i, bm.vf_i, bm.sf_i, bm.branch_i, bm.jump_i} = '0;
    {bm.mem_read_i, bm.mem_write_i, bm.reg_write_i, bm.mem_to_reg_i} = '0;
    bm.funct3_i = '0; bm.rd_i = '0; bm.alu_r_i = '0;
    bm.rs2_data_i = '0; bm.target_i = '0; bm.pc_plus4_i = '0;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] tgt);
    clear_inputs();
    {bm.cf_i, bm.zf_i, bm.vf_i, bm.sf_i} = sub_flags(a, b);
    bm.valid_i = 1'b1; bm.branch_i = 1'b1; bm.funct3_i = f3;
    bm.target_i = tgt; bm.alu_r_i = a - b;
  endtask

  task automatic drive_add(input logic [4:0] rd, input logic [31:0] res);
    clear_inputs();
    bm.valid_i = 1'b1; bm.reg_write_i = 1'b1; bm.rd_i = rd; bm.alu_r_i = res;
    bm.pc_plus4_i = 32'h0000_0044; bm.target_i = 32'hDEAD_0000;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if ({bm.valid_o, bm.pc_src_o, bm.reg_write_o, bm.mem_read_o, bm.mem_write_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000",
        {bm.valid_o, bm.pc_src_o, bm.reg_write_o, bm.mem_read_o, bm.mem_write_o});
    end
    checks++;
    if ({bm.target_o, bm.alu_r_o, bm.br_count_o, bm.taken_count_o} !== 96'd0) begin
      errors++; $display("FAIL reset_data got tgt=%h alu=%h br=%h tk=%h exp all 0",
        bm.target_o, bm.alu_r_o, bm.br_count_o, bm.taken_count_o);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_beq();
    drive_branch(3'b000, 32'd5, 32'd5, 32'h100);
    step();
    checks++;
    if ({bm.valid_o, bm.pc_src_o} !== 2'b11 || bm.target_o !== 32'h100) begin
      errors++; $display("FAIL beq_taken got v=%b pc_src=%b tgt=%h exp v=1 pc_src=1 tgt=00000100",
        bm.valid_o, bm.pc_src_o, bm.target_o);
    end
    checks++;
    if (bm.br_count_o !== 16'd1 || bm.taken_count_o !== 16'd1) begin
      errors++; $display("FAIL beq_counts got br=%0d tk=%0d exp br=1 tk=1", bm.br_count_o, bm.taken_count_o);
    end
    clear_inputs();
    step();
    checks++;
    if (bm.pc_src_o !== 1'b0 || bm.target_o !== 32'h0) begin
      errors++; $display("FAIL beq_one_cycle got pc_src=%b tgt=%h exp 0/0", bm.pc_src_o, bm.target_o);
    end
  endtask

  task automatic test_unsigned();
    drive_branch(3'b110, 32'd1, 32'hFFFF_FFFF, 32'h200);
    step();
    checks++;
    if (bm.pc_src_o !== 1'b1 || bm.target_o !== 32'h200 || bm.taken_count_o !== 16'd2) begin
      errors++; $display("FAIL bltu got pc_src=%b tgt=%h tk=%0d exp 1 00000200 2",
        bm.pc_src_o, bm.target_o, bm.taken_count_o);
    end
    clear_inputs();
    step();
    drive_branch(3'b111, 32'd1, 32'hFFFF_FFFF, 32'h300);
    step();
    checks++;
    if ({bm.valid_o, bm.pc_src_o} !== 2'b10 || bm.target_o !== 32'h0 || bm.funct3_o !== 3'b111) begin
      errors++; $display("FAIL bgeu got v=%b pc_src=%b tgt=%h f3=%b exp v=1 pc_src=0 tgt=0 f3=111",
        bm.valid_o, bm.pc_src_o, bm.target_o, bm.funct3_o);
    end
    checks++;
    if (bm.br_count_o !== 16'd3 || bm.taken_count_o !== 16'd2) begin
      errors++; $display("FAIL bgeu_counts got br=%0d tk=%0d exp br=3 tk=2", bm.br_count_o, bm.taken_count_o);
    end
  endtask

  task automatic test_signed();
    drive_branch(3'b100, 32'h8000_0000, 32'd1, 32'h400);
    step();
    checks++;
    if (bm.pc_src_o !== 1'b1 || bm.target_o !== 32'h400) begin
      errors++; $display("FAIL blt got pc_src=%b tgt=%h exp 1 00000400", bm.pc_src_o, bm.target_o);
    end
    clear_inputs();
    step();
    drive_branch(3'b101, 32'h8000_0000, 32'd1, 32'h500);
    step();
    checks++;
    if (bm.pc_src_o !== 1'b0 || bm.target_o !== 32'h0) begin
      errors++; $display("FAIL bge got pc_src=%b tgt=%h exp 0 0", bm.pc_src_o, bm.target_o);
    end
    drive_branch(3'b010, 32'd7, 32'd7, 32'h600);
    step();
    checks++;
    if (bm.pc_src_o !== 1'b0 || bm.br_count_o !== 16'd6 || bm.taken_count_o !== 16'd3) begin
      errors++; $display("FAIL f3_010 got pc_src=%b br=%0d tk=%0d exp 0 6 3",
        bm.pc_src_o, bm.br_count_o, bm.taken_count_o);
    end
  endtask

  task automatic test_squash();
    drive_branch(3'b001, 32'd1, 32'd2, 32'h700);
    step();
    drive_add(5'd5, 32'h1234);
    step();
    checks++;
    if ({bm.valid_o, bm.reg_write_o, bm.pc_src_o} !== 3'b000 || bm.rd_o !== 5'd0) begin
      errors++; $display("FAIL squash got v=%b rw=%b pc_src=%b rd=%0d exp 0 0 0 0",
        bm.valid_o, bm.reg_write_o, bm.pc_src_o, bm.rd_o);
    end
    step();
    checks++;
    if ({bm.valid_o, bm.reg_write_o} !== 2'b11 || bm.rd_o !== 5'd5 || bm.alu_r_o !== 32'h1234) begin
      errors++; $display("FAIL add_after got v=%b rw=%b rd=%0d alu=%h exp 1 1 5 00001234",
        bm.valid_o, bm.reg_write_o, bm.rd_o, bm.alu_r_o);
    end
  endtask

  task automatic test_stall_flush();
    drive_branch(3'b000, 32'd9, 32'd9, 32'h800);
    step();
    drive_add(5'd6, 32'h55);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bm.pc_src_o !== 1'b1 || bm.target_o !== 32'h800 || bm.br_count_o !== 16'd8) begin
        errors++; $display("FAIL stall_hold%0d got pc_src=%b tgt=%h br=%0d exp 1 00000800 8",
          i, bm.pc_src_o, bm.target_o, bm.br_count_o);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({bm.valid_o, bm.pc_src_o, bm.reg_write_o} !== 3'b000) begin
      errors++; $display("FAIL stall_squash got v=%b pc_src=%b rw=%b exp 000",
        bm.valid_o, bm.pc_src_o, bm.reg_write_o);
    end
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    checks++;
    if ({bm.valid_o, bm.reg_write_o} !== 2'b00 || bm.rd_o !== 5'd0) begin
      errors++; $display("FAIL flush_over_stall got v=%b rw=%b rd=%0d exp 0 0 0",
        bm.valid_o, bm.reg_write_o, bm.rd_o);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_jump();
    drive_branch(3'b001, 32'd3, 32'd3, 32'h900);
    bm.jump_i = 1'b1; bm.reg_write_i = 1'b1; bm.pc_plus4_i = 32'h88;
    step();
    checks++;
    if (bm.pc_src_o !== 1'b1 || bm.target_o !== 32'h900 || bm.pc_plus4_o !== 32'h88) begin
      errors++; $display("FAIL jump got pc_src=%b tgt=%h pc4=%h exp 1 00000900 00000088",
        bm.pc_src_o, bm.target_o, bm.pc_plus4_o);
    end
    checks++;
    if (bm.br_count_o !== 16'd8 || bm.taken_count_o !== 16'd5) begin
      errors++; $display("FAIL jump_counts got br=%0d tk=%0d exp 8 5", bm.br_count_o, bm.taken_count_o);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_saturation();
    {bs.cf_i, bs.zf_i, bs.vf_i, bs.sf_i} = 4'b0100;
    bs.valid_i = 1'b1; bs.branch_i = 1'b1; bs.funct3_i = 3'b000; bs.target_i = 32'h10;
    // Every other capture is self-squashed, so 20 edges give 10 counted branches.
    repeat (20) step();
    checks++;
    if (bs.br_count_o !== 4'd10 || bs.taken_count_o !== 4'd10) begin
      errors++; $display("FAIL sat_mid got br=%0d tk=%0d exp 10 10", bs.br_count_o, bs.taken_count_o);
    end
    repeat (30) step();
    checks++;
    if (bs.br_count_o !== 4'hF || bs.taken_count_o !== 4'hF) begin
      errors++; $display("FAIL sat_hold got br=%h tk=%h exp f f", bs.br_count_o, bs.taken_count_o);
    end
    bs.valid_i = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_branch(3'b000, 32'd4, 32'd4, 32'hA00);
    step();
    drive_add(5'd7, 32'h77);
    stall = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({bm.valid_o, bm.pc_src_o, bm.target_o, bm.br_count_o, bm.taken_count_o, bs.br_count_o} !== 70'd0) begin
      errors++; $display("FAIL async_reset got v=%b pc_src=%b tgt=%h br=%0d tk=%0d sbr=%0d exp all 0",
        bm.valid_o, bm.pc_src_o, bm.target_o, bm.br_count_o, bm.taken_count_o, bs.br_count_o);
    end
    step();
    rst = 1'b1; stall = 1'b0;
    step();
    checks++;
    if ({bm.valid_o, bm.reg_write_o} !== 2'b11 || bm.rd_o !== 5'd7) begin
      errors++; $display("FAIL post_reset_capture got v=%b rw=%b rd=%0d exp 1 1 7",
        bm.valid_o, bm.reg_write_o, bm.rd_o);
    end
  endtask

  initial begin
    bs.valid_i = 1'b0; bs.alu_r_i = '0; bs.cf_i = 1'b0; bs.zf_i = 1'b0; bs.vf_i = 1'b0;
    bs.sf_i = 1'b0; bs.funct3_i = '0; bs.branch_i = 1'b0; bs.jump_i = 1'b0;
    bs.mem_read_i = 1'b0; bs.mem_write_i = 1'b0; bs.reg_write_i = 1'b0; bs.mem_to_reg_i = 1'b0;
    bs.rd_i = '0; bs.rs2_data_i = '0; bs.target_i = '0; bs.pc_plus4_i = '0;
    test_reset();
    test_beq();
    test_unsigned();
    test_signed();
    test_squash();
    test_stall_flush();
    test_jump();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
